// File: rtl/fifo_drain_serializer.sv
// Pops full-width words from a one-cycle-latency FIFO into a 2-entry skid
// buffer and serializes each one into LANES narrow valid/ready beats.
module fifo_drain_serializer #(
    parameter  int OUT_WIDTH   = 8,
    parameter  int LANES       = 4,
    parameter  int COUNT_WIDTH = 16,
    localparam int IN_WIDTH    = OUT_WIDTH * LANES
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   fifo_empty,
    output logic                   fifo_pop_n,
    input  logic [IN_WIDTH-1:0]    fifo_data,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_first,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] drained_count,
    output logic                   busy
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    logic [IN_WIDTH-1:0]    slot_q [2];
    logic [IN_WIDTH-1:0]    slot_d [2];
    logic [1:0]             occ_q, occ_d;
    logic                   head_q, head_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic                   inflight_q, inflight_d;
    logic                   drop_q, drop_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic       fire;
    logic       consume;
    logic       capture;
    logic       pop;
    logic       head_next;
    logic       wr_idx;
    logic [1:0] occ_after;
    logic [2:0] pending;

    always_comb begin
        fire      = (occ_q != 2'd0) && out_ready;
        consume   = fire && (lane_q == LAST_LANE);
        occ_after = occ_q - {1'b0, consume};
        // Slots already committed once this cycle's consume and arrival settle.
        pending   = {1'b0, occ_after} + {2'b00, inflight_q};
        pop       = !fifo_empty && !clear && (pending < 3'd2);
        capture   = inflight_q && !drop_q && !clear;
        head_next = head_q ^ consume;
        wr_idx    = head_next ^ occ_after[0];

        slot_d[0]  = slot_q[0];
        slot_d[1]  = slot_q[1];
        occ_d      = occ_q;
        head_d     = head_q;
        lane_d     = lane_q;
        count_d    = count_q;
        drop_d     = 1'b0;
        inflight_d = pop;

        if (clear) begin
            occ_d   = 2'd0;
            head_d  = 1'b0;
            lane_d  = '0;
            count_d = '0;
            drop_d  = inflight_q;
        end else begin
            occ_d  = occ_after + {1'b0, capture};
            head_d = head_next;
            if (fire) begin
                lane_d = consume ? '0 : lane_q + 1'b1;
            end
            if (consume) begin
                count_d = count_q + 1'b1;
            end
            if (capture) begin
                slot_d[wr_idx] = fifo_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
            occ_q      <= 2'd0;
            head_q     <= 1'b0;
            lane_q     <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            slot_q[0]  <= slot_d[0];
            slot_q[1]  <= slot_d[1];
            occ_q      <= occ_d;
            head_q     <= head_d;
            lane_q     <= lane_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
        end
    end

    assign fifo_pop_n    = !pop;
    assign out_valid     = (occ_q != 2'd0);
    assign out_data      = slot_q[head_q][lane_q*OUT_WIDTH +: OUT_WIDTH];
    assign out_first     = (lane_q == '0);
    assign out_last      = (lane_q == LAST_LANE);
    assign drained_count = count_q;
    assign busy          = (occ_q != 2'd0) || inflight_q;

endmodule
